uart_term_ctrl: RTL
===================

Name: uart_term_ctrl

Overview:
Terminal controller between the UART receiver and the character memory write port of the VGA text path.
- Interprets each received byte as a printable character or a control code.
- Maintains the cursor position on a COLS x ROWS text grid.
- Sequences all character-memory writes, including the multi-cycle clear-screen fill.
- Owns the memory write port exclusively.

Parameters:
COLS, 80, text columns per row
ROWS, 30, text rows
ADDR_W, 12, character memory address width; COLS*ROWS must be <= 2**ADDR_W
BLANK_CHAR, 8'h20, code written by clear and backspace

Ports:
clock100  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
data_in  in  8  received byte, valid when data_ready=1
data_ready  in  1  single-cycle strobe from UART receiver
data_out  out  8  character memory write data
wraddress  out  ADDR_W  character memory write address
wren  out  1  character memory write enable
cursor_addr  out  ADDR_W  current cursor linear address (row*COLS+col)
busy  out  1  high while clear-screen fill runs
overrun  out  1  sticky: byte lost while busy

Behaviour:
- Clocking: all state updates on posedge clock100. Reset is synchronous, active-high, and wins over data_ready in the same cycle (byte dropped).
- Reset values: data_out=0, wraddress=0, wren=0, cursor_addr=0, busy=0, overrun=0, state=IDLE, pending empty.
- Address generation: col, row and linear addr are held as counters, stepped incrementally. No multiplier.
- Write timing: outputs are registered. data_ready sampled at edge N gives wren=1 for exactly the cycle after edge N.
- State IDLE, on data_ready, by data_in:
  - 0x20-0x7E: write data_in at cursor, then advance col. At col=COLS-1 go to col 0, row+1. At last row/col wrap to addr 0. No scrolling.
  - 0x0D (CR): col=0. No write.
  - 0x0A (LF): row+1, wrapping ROWS-1 -> 0. col unchanged. No write.
  - 0x08 (BS): if col>0, col-1, then write BLANK_CHAR at the new position. At col=0: no-op.
  - 0x0C (FF): enter CLEAR, busy=1.
  - Any other code: ignored, no write.
- State CLEAR:
  - Writes BLANK_CHAR to addresses 0..COLS*ROWS-1, one per cycle, ascending.
  - wren stays high for exactly COLS*ROWS consecutive cycles.
  - After the last write: cursor=0, busy=0, return to IDLE.
- Byte arriving during CLEAR:
  - Latched into a 1-deep pending register.
  - Processed in the first IDLE cycle after CLEAR ends, with normal timing.
  - A second byte while pending is full is dropped and sets overrun=1. overrun clears only on reset.
- Reset mid-CLEAR: fill aborted, wren=0 from the next cycle, memory contents undefined.
- data_ready held high for multiple cycles: each high cycle is a separate byte.

Optional Feature:
Macro UART_TERM_ESC_EN.
- Defined: ESC (0x1B) starts a direct cursor-positioning sequence ESC, r, c.
  - Sets row=min(r,ROWS-1) and col=min(c,COLS-1).
  - Adds states ESC_ROW and ESC_COL. No memory writes.
  - FF received inside the sequence aborts it and clears the screen.
- Undefined: 0x1B is ignored like any other unlisted code. No ESC states exist.

Decomposition:
- Package uart_term_pkg: character code constants (CHAR_CR, CHAR_LF, CHAR_BS, CHAR_FF, CHAR_ESC), printable range bounds, state enum (IDLE, CLEAR, ESC_ROW, ESC_COL).
- Sub-module term_cursor: col/row/linear-addr counters with ops hold, advance, newline, carriage return, back, home, load(r,c). Outputs col, row, addr.

Test Plan:
- Reset, then byte 0x40 with one-cycle data_ready -> one cycle later wren=1, data_out=0x40, wraddress=0. cursor_addr becomes 1.
- Cursor at col 79 row 0, send 0x41 -> write at addr 79. Cursor becomes 80 (row 1, col 0).
- Cursor at 2399, send 0x42 -> write at 2399. Cursor wraps to 0.
- Cursor at 85, send 0x0D then 0x0A -> cursor 160, no wren pulses. Then 0x08 -> cursor stays 160, no write.
- Send 0x0C, then 0x43 on clear cycle 100, then 0x44 on cycle 200:
  - wren high 2400 consecutive cycles with data 0x20 and addresses 0..2399.
  - busy falls, then 0x43 is written at addr 0.
  - 0x44 is dropped and overrun=1.
- With UART_TERM_ESC_EN: send 0x1B, 0x05, 0x63 -> cursor = 5*80+79 = 479. Assert reset mid-clear -> wren=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/uart_term_pkg.sv
// Shared definitions for the UART terminal controller: control-code constants,
// the printable range, FSM states and cursor operations.
// With UART_TERM_ESC_EN defined, the ESC_ROW/ESC_COL states exist.
package uart_term_pkg;

  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_FF  = 8'h0C;
  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_ESC = 8'h1B;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

`ifdef UART_TERM_ESC_EN
  typedef enum logic [1:0] {IDLE, CLEAR, ESC_ROW, ESC_COL} term_state_t;
`else
  typedef enum logic [0:0] {IDLE, CLEAR} term_state_t;
`endif

  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_ADVANCE,
    CUR_NEWLINE,
    CUR_CR,
    CUR_BACK,
    CUR_HOME,
    CUR_LOAD
  } cur_op_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/term_cursor.sv
// Cursor counters for the text grid. Column, row and linear address are kept
// as separate counters and stepped incrementally, so no run-time multiply is
// needed. A direct load takes the row base from a constant per-row table.
module term_cursor
  import uart_term_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  cur_op_t           op,
  input  logic [7:0]        ld_row,
  input  logic [7:0]        ld_col,
  output logic [ADDR_W-1:0] col,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] lr;
  logic [ADDR_W-1:0] lc;

  function automatic logic [ADDR_W-1:0] clamp(input logic [7:0] v, input int lim);
    if (int'(v) > lim - 1) return ADDR_W'(lim - 1);
    return ADDR_W'(v);
  endfunction

  // Constant table lookup of r*COLS; every entry folds at elaboration.
  function automatic logic [ADDR_W-1:0] row_base(input logic [ADDR_W-1:0] r);
    logic [ADDR_W-1:0] b;
    b = '0;
    for (int i = 0; i < ROWS; i++)
      if (r == ADDR_W'(i)) b = ADDR_W'(i * COLS);
    return b;
  endfunction

  assign lr = clamp(ld_row, ROWS);
  assign lc = clamp(ld_col, COLS);

  // Step the cursor counters according to the requested operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else begin
      case (op)
        CUR_ADVANCE: begin
          if (col == LAST_COL) begin
            col <= '0;
            if (row == LAST_ROW) begin
              row  <= '0;
              addr <= '0;
            end else begin
              row  <= row + ONE;
              addr <= addr + ONE;
            end
          end else begin
            col  <= col + ONE;
            addr <= addr + ONE;
          end
        end
        CUR_NEWLINE: begin
          if (row == LAST_ROW) begin
            row  <= '0;
            addr <= col;
          end else begin
            row  <= row + ONE;
            addr <= addr + ROW_STEP;
          end
        end
        CUR_CR: begin
          col  <= '0;
          addr <= addr - col;
        end
        CUR_BACK: begin
          if (col != '0) begin
            col  <= col - ONE;
            addr <= addr - ONE;
          end
        end
        CUR_HOME: begin
          col  <= '0;
          row  <= '0;
          addr <= '0;
        end
        CUR_LOAD: begin
          row  <= lr;
          col  <= lc;
          addr <= row_base(lr) + lc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_term_ctrl.sv
// Terminal controller between the UART receiver and the character memory
// write port. Decodes bytes, drives the cursor and owns every memory write,
// including the one-cell-per-cycle clear-screen fill.
// Optional macro UART_TERM_ESC_EN enables the ESC,row,col cursor sequence.
module uart_term_ctrl
  import uart_term_pkg::*;
#(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter int         ADDR_W     = 12,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic              clock100,
  input  logic              reset,
  input  logic [7:0]        data_in,
  input  logic              data_ready,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] wraddress,
  output logic              wren,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W:0]   CELLS   = (ADDR_W + 1)'(COLS * ROWS);
  localparam logic [ADDR_W:0]   CLR_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  term_state_t       state;
  cur_op_t           op;
  logic              pend_vld;
  logic [7:0]        pend_byte;
  logic [ADDR_W:0]   clr_next;
  logic              in_vld;
  logic [7:0]        in_byte;
  logic [7:0]        ld_row;
  logic [ADDR_W-1:0] cur_col;

  // A byte held over from a clear is always consumed before a fresh one.
  assign in_vld  = pend_vld | data_ready;
  assign in_byte = pend_vld ? pend_byte : data_in;

`ifdef UART_TERM_ESC_EN
  logic [7:0] esc_row;
  assign ld_row = esc_row;
`else
  assign ld_row = 8'h00;
`endif

  term_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk    (clock100),
    .rst    (reset),
    .op     (op),
    .ld_row (ld_row),
    .ld_col (in_byte),
    .col    (cur_col),
    .addr   (cursor_addr)
  );

  // Decode the cursor operation for this cycle from state and input byte.
  always_comb begin
    op = CUR_HOLD;
    case (state)
      IDLE: begin
        if (in_vld) begin
          if (is_printable(in_byte)) op = CUR_ADVANCE;
          else begin
            case (in_byte)
              CHAR_CR: op = CUR_CR;
              CHAR_LF: op = CUR_NEWLINE;
              CHAR_BS: op = CUR_BACK;
              default: ;
            endcase
          end
        end
      end
      CLEAR: if (clr_next == CELLS) op = CUR_HOME;
`ifdef UART_TERM_ESC_EN
      ESC_COL: if (in_vld && in_byte != CHAR_FF) op = CUR_LOAD;
`endif
      default: ;
    endcase
  end

  // Main FSM with registered memory-port outputs and the pending-byte slot.
  always_ff @(posedge clock100) begin
    if (reset) begin
      state     <= IDLE;
      wren      <= 1'b0;
      data_out  <= 8'h00;
      wraddress <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      pend_vld  <= 1'b0;
      pend_byte <= 8'h00;
      clr_next  <= '0;
`ifdef UART_TERM_ESC_EN
      esc_row   <= 8'h00;
`endif
    end else begin
      wren <= 1'b0;
      if (state == CLEAR) begin
        if (data_ready) begin
          if (pend_vld) overrun <= 1'b1;
          else begin
            pend_vld  <= 1'b1;
            pend_byte <= data_in;
          end
        end
        if (clr_next == CELLS) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          wren      <= 1'b1;
          data_out  <= BLANK_CHAR;
          wraddress <= clr_next[ADDR_W-1:0];
          clr_next  <= clr_next + CLR_ONE;
        end
      end else begin
        // Draining the slot frees it for a byte arriving in the same cycle.
        pend_vld <= pend_vld & data_ready;
        if (pend_vld & data_ready) pend_byte <= data_in;
        if (in_vld) begin
          if (in_byte == CHAR_FF) begin
            // First fill write goes out immediately; the rest follow from CLEAR.
            state     <= CLEAR;
            busy      <= 1'b1;
            wren      <= 1'b1;
            data_out  <= BLANK_CHAR;
            wraddress <= '0;
            clr_next  <= CLR_ONE;
          end else begin
            case (state)
              IDLE: begin
                if (is_printable(in_byte)) begin
                  wren      <= 1'b1;
                  data_out  <= in_byte;
                  wraddress <= cursor_addr;
                end else if (in_byte == CHAR_BS && cur_col != '0) begin
                  wren      <= 1'b1;
                  data_out  <= BLANK_CHAR;
                  wraddress <= cursor_addr - ONE;
                end
`ifdef UART_TERM_ESC_EN
                else if (in_byte == CHAR_ESC) begin
                  state <= ESC_ROW;
                end
`endif
              end
`ifdef UART_TERM_ESC_EN
              ESC_ROW: begin
                esc_row <= in_byte;
                state   <= ESC_COL;
              end
              ESC_COL: state <= IDLE;
`endif
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule
